// File: rtl/stream_cipher_pkg.sv
// rtl/stream_cipher_pkg.sv - shared FSM states, tag layout and defaults for stream_cipher_arbiter
package stream_cipher_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_CORE_LAT = 2;
  // Widest channel index needed for the largest supported NUM_CH (8)
  localparam int CH_W_MAX     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_XFER  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [CH_W_MAX-1:0] ch;
    logic                last;
  } cipher_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at the channel after ptr
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     ptr,
  output logic              gnt_any,
  output logic [CW-1:0]     gnt_idx
);

  int            cand;
  logic [CW-1:0] cand_idx;

  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    // Walk NUM_CH positions beginning one past ptr, so ptr itself is checked last
    for (int i = 1; i <= NUM_CH; i++) begin
      cand     = (int'(ptr) + i) % NUM_CH;
      cand_idx = CW'(cand);
      if (!gnt_any && req[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/stream_cipher_arbiter.sv
// rtl/stream_cipher_arbiter.sv - round-robin packet arbiter feeding one shared cipher core; ARB_TIMEOUT_EN adds a mid-packet idle timeout
module stream_cipher_arbiter
  import stream_cipher_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CORE_LAT = DEF_CORE_LAT,
  parameter int TO_CYC   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         req_valid,
  input  logic [NUM_CH*8-1:0]       req_char,
  input  logic [NUM_CH*8-1:0]       req_key,
  input  logic [NUM_CH-1:0]         req_last,
  output logic [NUM_CH-1:0]         req_ready,
  output logic                      core_din_valid,
  output logic [7:0]                core_key,
  output logic [7:0]                core_txt_in,
  input  logic [7:0]                core_txt_out,
  input  logic                      core_dout_ready,
  output logic                      out_valid,
  output logic [7:0]                out_char,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_last,
  output logic                      busy,
`ifdef ARB_TIMEOUT_EN
  output logic                      err_timeout,
`endif
  output logic                      err_sync
);

  localparam int CW    = $clog2(NUM_CH);
  localparam int DEPTH = CORE_LAT + 1;

  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
    $error("stream_cipher_arbiter: NUM_CH must be 2..8");
  end
  if (CORE_LAT < 0 || CORE_LAT > 250) begin : g_bad_core_lat
    $error("stream_cipher_arbiter: CORE_LAT out of range");
  end
  if (TO_CYC < 1) begin : g_bad_to_cyc
    $error("stream_cipher_arbiter: TO_CYC must be at least 1");
  end

  arb_state_t    state_q, state_d;
  logic [CW-1:0] rr_ptr_q;
  logic [CW-1:0] grant_q;
  logic [CW-1:0] arb_idx;
  logic          arb_any;
  logic [7:0]    key_q;
  logic [7:0]    arb_key;
  logic [7:0]    sel_char;
  logic          sel_valid;
  logic          sel_last;
  logic          accept;
  logic          to_hit;
  logic          din_valid_q;
  logic [7:0]    txt_in_q;
  logic [7:0]    drain_cnt_q;
  logic          err_sync_q;
  cipher_tag_t   tag_q [DEPTH];
  cipher_tag_t   tag_in;
  cipher_tag_t   tag_tail;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt_any (arb_any),
    .gnt_idx (arb_idx)
  );

  // Per-channel field selection: the active grant for data, the candidate for the key
  always_comb begin
    sel_valid = 1'b0;
    sel_char  = '0;
    sel_last  = 1'b0;
    arb_key   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CW'(i) == grant_q) begin
        sel_valid = req_valid[i];
        sel_char  = req_char[8*i +: 8];
        sel_last  = req_last[i];
      end
      if (CW'(i) == arb_idx) begin
        arb_key = req_key[8*i +: 8];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        err_timeout_q;

  assign to_hit = (state_q == ST_XFER) && !sel_valid && (to_cnt_q == 16'(TO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (state_q != ST_XFER || sel_valid) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 16'd1;
      end
      if (to_hit) begin
        err_timeout_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) state_d = ST_ARB;
      end
      ST_ARB: begin
        // A requester that withdrew before the grant leaves nothing to serve
        state_d = arb_any ? ST_XFER : ST_IDLE;
      end
      ST_XFER: begin
        req_ready = NUM_CH'(1) << grant_q;
        accept    = sel_valid;
        if ((sel_valid && sel_last) || to_hit) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt_q == 8'd0) state_d = (|req_valid) ? ST_ARB : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = accept;
    tag_in.ch    = accept ? CH_W_MAX'(grant_q) : '0;
    tag_in.last  = accept && sel_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= CW'(NUM_CH - 1);
      grant_q     <= '0;
      key_q       <= '0;
      din_valid_q <= 1'b0;
      txt_in_q    <= '0;
      drain_cnt_q <= '0;
      err_sync_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ARB && arb_any) begin
        grant_q  <= arb_idx;
        rr_ptr_q <= arb_idx;
        key_q    <= arb_key;
      end
      din_valid_q <= accept;
      if (accept) txt_in_q <= sel_char;
      // Preloaded outside DRAIN so the first DRAIN cycle sees CORE_LAT and the last sees 0
      if (state_q != ST_DRAIN) begin
        drain_cnt_q <= 8'(CORE_LAT);
      end else begin
        drain_cnt_q <= drain_cnt_q - 8'd1;
      end
      tag_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
      if (core_dout_ready != tag_tail.valid) err_sync_q <= 1'b1;
    end
  end

  assign tag_tail       = tag_q[DEPTH-1];
  assign busy           = (state_q != ST_IDLE);
  assign core_din_valid = din_valid_q;
  assign core_txt_in    = txt_in_q;
  assign core_key       = key_q;
  assign out_valid      = core_dout_ready;
  assign out_char       = core_txt_out;
  assign out_ch         = CW'(tag_tail.ch);
  assign out_last       = tag_tail.last;
  assign err_sync       = err_sync_q;

endmodule
